// File: rtl/servo_pwm_meas.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_meas
//  Purpose  : Measures servo PWM high time and rise-to-rise period in whole
//             microseconds. Flags loss of signal and over-long pulses.
//  Options  : SERVO_MEAS_FILTER_EN - glitch filter of 3 identical samples
//             placed after the synchroniser. It adds 2 cycles to both edges.
//  Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_meas #(
  parameter int CLK_PER_US  = 50,
  parameter int TIMEOUT_US  = 25000,
  parameter int MAX_HIGH_US = 3000
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [14:0] width_us,
  output logic [14:0] period_us,
  output logic        meas_valid,
  output logic        overrange,
  output logic        signal_lost
);

  localparam logic [5:0]  C_PRE_LAST = 6'(CLK_PER_US - 1);
  localparam logic [14:0] C_SAT      = 15'h7FFF;
  localparam logic [14:0] C_TIMEOUT  = 15'(TIMEOUT_US);
  localparam logic [14:0] C_MAX_HIGH = 15'(MAX_HIGH_US);

  typedef enum logic [1:0] {
    S_SYNC      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_HIGH      = 2'd2,
    S_LOW       = 2'd3
  } state_t;

  state_t      r_state, w_state_next;
  logic [1:0]  r_sync;
  logic        r_lvl_d;
  logic        w_lvl, w_rise, w_fall;
  logic [5:0]  r_presc;
  logic [14:0] r_hi_cnt, r_per_cnt, r_width_cap;
  logic [14:0] r_width, r_period;
  logic        r_meas, r_over, r_lost;
  logic [14:0] w_hi_inc, w_per_inc;
  logic        w_tick, w_timeout;
  logic        w_clear, w_cap, w_meas, w_lost;

  // Synchroniser and previous-level register. These reset to 1 so that a line
  // held high through reset cannot produce a false rise.
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      r_sync  <= 2'b11;
      r_lvl_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], pwm_in};
      r_lvl_d <= w_lvl;
    end
  end

`ifdef SERVO_MEAS_FILTER_EN
  logic [1:0] r_hist;

  // Sample history for the glitch filter. r_lvl_d holds the filtered level.
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) r_hist <= 2'b11;
    else        r_hist <= {r_hist[0], r_sync[1]};
  end

  assign w_lvl = (r_sync[1] == r_hist[0] && r_hist[0] == r_hist[1]) ? r_sync[1] : r_lvl_d;
`else
  assign w_lvl = r_sync[1];
`endif

  assign w_rise    = w_lvl & ~r_lvl_d;
  assign w_fall    = ~w_lvl & r_lvl_d;
  assign w_tick    = (r_presc == C_PRE_LAST);
  assign w_hi_inc  = (r_hi_cnt == C_SAT) ? r_hi_cnt : r_hi_cnt + 15'd1;
  assign w_per_inc = (r_per_cnt == C_SAT) ? r_per_cnt : r_per_cnt + 15'd1;
  // The timeout fires on the tick that brings per_cnt to TIMEOUT_US.
  assign w_timeout = w_tick && (w_per_inc == C_TIMEOUT);

  // FSM state register
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) r_state <= S_SYNC;
    else        r_state <= w_state_next;
  end

  // Next state and control strobes. A timeout overrides any edge in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_cap        = 1'b0;
    w_meas       = 1'b0;
    w_lost       = 1'b0;
    if (w_timeout) begin
      w_state_next = S_SYNC;
      w_clear      = 1'b1;
      w_lost       = 1'b1;
    end else begin
      case (r_state)
        S_SYNC:      if (!w_lvl) w_state_next = S_WAIT_RISE;
        S_WAIT_RISE: if (w_rise) begin
                       w_state_next = S_HIGH;
                       w_clear      = 1'b1;
                     end
        S_HIGH:      if (w_fall) begin
                       w_state_next = S_LOW;
                       w_cap        = 1'b1;
                     end
        S_LOW:       if (w_rise) begin
                       w_state_next = S_HIGH;
                       w_clear      = 1'b1;
                       w_meas       = 1'b1;
                     end
        default:     w_state_next = S_SYNC;
      endcase
    end
  end

  // Prescaler, saturating counters, width capture and output registers.
  // Captures take count+1, so whole-microsecond pulses read exactly and
  // fractional pulses round up.
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      r_presc     <= 6'd0;
      r_hi_cnt    <= 15'd0;
      r_per_cnt   <= 15'd0;
      r_width_cap <= 15'd0;
      r_width     <= 15'd0;
      r_period    <= 15'd0;
      r_meas      <= 1'b0;
      r_over      <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_meas <= w_meas;
      if (w_clear) begin
        r_presc   <= 6'd0;
        r_hi_cnt  <= 15'd0;
        r_per_cnt <= 15'd0;
      end else begin
        r_presc <= w_tick ? 6'd0 : r_presc + 6'd1;
        if (w_tick) begin
          r_hi_cnt  <= w_hi_inc;
          r_per_cnt <= w_per_inc;
        end
      end
      if (w_cap) r_width_cap <= w_hi_inc;
      if (w_meas) begin
        r_period <= w_per_inc;
        r_width  <= (r_width_cap > C_MAX_HIGH) ? C_MAX_HIGH : r_width_cap;
        r_over   <= (r_width_cap > C_MAX_HIGH);
        r_lost   <= 1'b0;
      end
      if (w_lost) r_lost <= 1'b1;
    end
  end

  assign width_us    = r_width;
  assign period_us   = r_period;
  assign meas_valid  = r_meas;
  assign overrange   = r_over;
  assign signal_lost = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_meas.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_servo_pwm_meas
//  Purpose  : Self-checking bench for servo_pwm_meas. It uses scaled-down
//             timing parameters and a pulse-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_meas;

  localparam int C      = 3;    // clocks per microsecond
  localparam int T      = 200;  // timeout, us
  localparam int MAXH   = 120;  // maximum legal high time, us
  localparam int CLK_NS = 20;
`ifdef SERVO_MEAS_FILTER_EN
  localparam int LAT_CYC = 5;
`else
  localparam int LAT_CYC = 3;
`endif

  logic        clk_50M = 1'b0;
  logic        reset   = 1'b0;
  logic        pwm_in  = 1'b0;
  logic [14:0] width_us, period_us;
  logic        meas_valid, overrange, signal_lost;

  servo_pwm_meas #(.CLK_PER_US(C), .TIMEOUT_US(T), .MAX_HIGH_US(MAXH)) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .width_us    (width_us),
    .period_us   (period_us),
    .meas_valid  (meas_valid),
    .overrange   (overrange),
    .signal_lost (signal_lost)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct { int w; int p; int ov; int lost; longint t; } rec_t;
  rec_t   q[$];
  logic   lost_d    = 1'b0;
  longint t_lost    = 0;
  int     n_lost_ev = 0;
  int     n_assert  = 0;
  int     n_fail    = 0;
  int     m_armed   = 0;
  int     prev_hc   = 0;
  int     prev_pc   = 0;
  int     glitch_pend = 0;
  longint t_rise    = 0;

  // Record every measurement strobe and the first cycle of each loss event.
  always @(negedge clk_50M) begin
    rec_t r;
    if (meas_valid === 1'b1) begin
      r.w    = int'(width_us);
      r.p    = int'(period_us);
      r.ov   = int'(overrange);
      r.lost = int'(signal_lost);
      r.t    = longint'($time);
      q.push_back(r);
    end
    if (signal_lost === 1'b1 && lost_d !== 1'b1) begin
      t_lost = longint'($time);
      n_lost_ev++;
    end
    lost_d = signal_lost;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: values are rounded up to whole microseconds, and the
  // width is clamped to the maximum legal high time.
  function automatic int exp_w(input int hc);
    int u;
    u = (hc + C - 1) / C;
    return (u > MAXH) ? MAXH : u;
  endfunction
  function automatic int exp_ov(input int hc);
    return (((hc + C - 1) / C) > MAXH) ? 1 : 0;
  endfunction
  function automatic int exp_p(input int pc);
    return (pc + C - 1) / C;
  endfunction

  // Drive a rise. Check that the measurement of the previous pulse appears
  // (or does not appear) with the expected latency. Holds the line high for 8 cycles.
  task automatic do_rise();
    rec_t r;
    pwm_in = 1'b1;
    t_rise = longint'($time);
    repeat (8) @(negedge clk_50M);
    if (glitch_pend != 0) begin
      glitch_pend = 0;
`ifdef SERVO_MEAS_FILTER_EN
      chk("glitch_nmeas", q.size(), 1);
      if (q.size() > 0) begin
        r = q.pop_back();
        chk("glitch_width", r.w, exp_w(prev_hc));
      end
`else
      chk("glitch_nmeas", q.size(), 2);
      if (q.size() > 0) begin
        r = q.pop_back();
        chk("glitch_short", (r.w < exp_w(prev_hc)) ? 1 : 0, 1);
      end
`endif
      q.delete();
    end else if (m_armed != 0) begin
      chk("nmeas", q.size(), 1);
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("width", r.w, exp_w(prev_hc));
        chk("period", r.p, exp_p(prev_pc));
        chk("overrange", r.ov, exp_ov(prev_hc));
        chk("lost_clr", r.lost, 0);
        chk("latency", r.t - t_rise, LAT_CYC * CLK_NS);
      end
    end else begin
      chk("no_meas", q.size(), 0);
    end
    m_armed = 1;
  endtask

  task automatic send(input int hc, input int pc);
    do_rise();
    repeat (hc - 8) @(negedge clk_50M);
    pwm_in = 1'b0;
    repeat (pc - hc) @(negedge clk_50M);
    prev_hc = hc;
    prev_pc = pc;
  endtask

  // Pulse with a 2-cycle low glitch near its middle.
  task automatic send_glitch(input int hc, input int pc);
    do_rise();
    repeat (hc / 2 - 8) @(negedge clk_50M);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk_50M);
    pwm_in = 1'b1;
    repeat (hc - hc / 2 - 2) @(negedge clk_50M);
    pwm_in = 1'b0;
    repeat (pc - hc) @(negedge clk_50M);
    prev_hc     = hc;
    prev_pc     = pc;
    glitch_pend = 1;
  endtask

  initial begin
    int hc, pc;
    // Reset state
    repeat (3) @(negedge clk_50M);
    chk("rst_width", width_us, 0);
    chk("rst_period", period_us, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_over", overrange, 0);
    chk("rst_lost", signal_lost, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk_50M);

    // Nominal pulse train: measurements start at the second rise.
    repeat (5) send(60 * C, 160 * C);

    // Range extremes, then fractional microsecond pulse and period (round up)
    send(40 * C, 160 * C);
    send(80 * C, 160 * C);
    send(60 * C + 1, 160 * C + 2);
    send(60 * C, 160 * C);

    // Randomised pulses. Some are overrange, and all periods are below the timeout.
    for (int i = 0; i < 12; i++) begin
      hc = int'($urandom_range(10 * C, 135 * C));
      pc = int'($urandom_range(hc + 10 * C, 190 * C));
      send(hc, pc);
    end

    // Overrange, then a normal pulse clears the flag
    send(140 * C, 180 * C);
    send(60 * C, 160 * C);
    send(60 * C, 160 * C);

    // Loss of signal and recovery
    n_lost_ev = 0;
    repeat (300 * C) @(negedge clk_50M);
    chk("lost_level", signal_lost, 1);
    chk("lost_events", n_lost_ev, 1);
    chk("lost_time", t_lost - t_rise, (T * C + LAT_CYC) * CLK_NS);
    chk("hold_width", width_us, 60);
    chk("hold_period", period_us, 160);
    chk("lost_nmeas", q.size(), 0);
    m_armed = 0;
    send(60 * C, 160 * C);
    chk("lost_still", signal_lost, 1);
    send(75 * C, 170 * C);
    chk("lost_cleared", signal_lost, 0);
    send(60 * C, 160 * C);

    // Reset asserted in the middle of a high phase
    do_rise();
    repeat (70 * C - 8) @(negedge clk_50M);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_width", width_us, 0);
    chk("mid_rst_period", period_us, 0);
    chk("mid_rst_valid", meas_valid, 0);
    chk("mid_rst_over", overrange, 0);
    chk("mid_rst_lost", signal_lost, 0);
    q.delete();
    m_armed = 0;
    repeat (5) @(negedge clk_50M);
    reset = 1'b1;
    repeat (30 * C) @(negedge clk_50M);
    chk("rel_high_nmeas", q.size(), 0);
    pwm_in = 1'b0;
    repeat (50 * C) @(negedge clk_50M);
    send(60 * C, 160 * C);
    send(75 * C, 160 * C);

    // Glitch inside a pulse. The next clean period must measure correctly.
    send(60 * C, 160 * C);
    send_glitch(60 * C, 160 * C);
    send(60 * C, 160 * C);
    send(70 * C, 150 * C);
    do_rise();
    pwm_in = 1'b0;
    repeat (20) @(negedge clk_50M);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/servo_pwm_meas.md
# servo_pwm_meas

Measures an incoming hobby-servo PWM signal and reports its high time and period in whole microseconds, using the same 15-bit, 1 µs resolution the servo drivers are programmed with. It sits on the clk_50M domain next to the motor-control path. It is used for closed-loop checking of the pan/tilt servo commands and for reading an external RC receiver. It also flags loss of signal and out-of-range pulses.

## Interface
Parameters:
- CLK_PER_US, 50, clk_50M cycles per microsecond tick (2..63)
- TIMEOUT_US, 25000, µs without a rising edge before the signal is declared lost (< 32767)
- MAX_HIGH_US, 3000, largest legal high time; longer pulses are clamped and flagged

Ports:
- clk_50M  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- pwm_in  in  1  asynchronous servo PWM input
- width_us  out  15  last complete high time, µs
- period_us  out  15  last complete rise-to-rise period, µs
- meas_valid  out  1  one-cycle strobe when width_us/period_us update
- overrange  out  1  last measurement had high time > MAX_HIGH_US
- signal_lost  out  1  no rising edge for TIMEOUT_US

## Operation
- **Input synchronisation:** pwm_in passes through a 2-FF synchroniser, then an edge register; rise/fall are single-cycle detects on the synchronised level.
- **Microsecond prescaler:** 6-bit counter 0..CLK_PER_US-1; tick when == CLK_PER_US-1. Cleared on every detected rise, so an integer-µs pulse measures exactly.
- **Counters:** hi_cnt and per_cnt, 15 bits, increment on tick, saturate at 32767 (no wrap).
- **FSM states:** SYNC, WAIT_RISE, HIGH, LOW.
  - SYNC (reset state): wait for synchronised level = 0, then go to WAIT_RISE. This discards a partial pulse after reset or timeout.
  - WAIT_RISE: on rise, clear hi_cnt/per_cnt/prescaler and go to HIGH.
  - HIGH: on fall, capture hi_cnt into width_cap and go to LOW.
  - LOW: on rise, period_us <= per_cnt and width_us <= min(width_cap, MAX_HIGH_US); overrange <= (width_cap > MAX_HIGH_US); pulse meas_valid; signal_lost <= 0; clear counters and prescaler; go to HIGH.
- **Timeout:** in any state, per_cnt reaching TIMEOUT_US sets signal_lost = 1, clears the counters and returns to SYNC. width_us and period_us hold their last values.
  - In SYNC/WAIT_RISE, per_cnt counts idle time.
  - A rise in the same cycle as timeout: the timeout wins and the edge is discarded.
- **Glitches:** a rise while in HIGH is impossible; a fall while in LOW or WAIT_RISE is ignored.

## Timing
- **Reset values:** width_us = 0, period_us = 0, meas_valid = 0, overrange = 0, signal_lost = 0, state = SYNC, counters = 0.
- **Latency, macro off:** the pwm_in rise is first sampled high at edge k. The synchronised level is valid after edge k+1, the rise is detected in the following cycle, and meas_valid and the outputs update at edge k+2.
- **Latency, macro on:** add 2 cycles to the above.
- **Output registers:** all outputs are registered. meas_valid is high for exactly one clk_50M cycle per period. Outputs change only on meas_valid, timeout or reset.
- **Reset mid-operation:** asynchronous return to reset values. The first measurement after reset is produced at the second rise following a low level.
- **Resolution:** −0/+1 µs per measurement for non-integer pulses; exact for integer-µs pulses.

## Configuration
- **SERVO_MEAS_FILTER_EN defined:** a glitch filter sits after the synchroniser. The filtered level changes only after 3 consecutive identical samples, so pulses ≤ 2 clk_50M cycles (40 ns) are rejected. This adds 2 cycles of latency to both edges; measured widths are unchanged.
- **SERVO_MEAS_FILTER_EN undefined:** the synchroniser output drives edge detection directly.

## Test plan
- **Nominal:** 1500 µs high / 20000 µs period, 5 periods -> from the 2nd rise onward meas_valid once per period; width_us = 1500, period_us = 20000, overrange = 0.
- **Range extremes:** 1000 µs high then 2000 µs high, 20 ms period -> width_us = 1000, then 2000, each exact; period_us = 20000.
- **Loss and recovery:** pwm_in held low for 30 ms after valid pulses -> signal_lost rises 25000 µs after the last rise and width_us holds 1500. On resumed pulses, signal_lost clears at the first new meas_valid, which occurs at the 2nd rise.
- **Overrange:** 3500 µs high / 20000 µs period -> width_us = 3000, overrange = 1. A following 1500 µs pulse gives overrange = 0.
- **Reset mid-pulse:** reset asserted 700 µs into a high phase -> all outputs 0 immediately. After release with the line still high, no meas_valid until the line goes low, rises, and rises again.
- **Glitch:** a 40 ns low glitch inside a 1500 µs pulse. With the macro defined: width_us = 1500. Without the macro: measured width < 1500, with no lockup and the next clean period correct.
